// File: rtl/draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : draw_arbiter_if
// Brief    : Requester-side rectangle requests and VGA adapter write port.
// Revision : 1.0
// ============================================================================
interface draw_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [8*NUM_REQ-1:0] req_w;
    logic [7*NUM_REQ-1:0] req_h;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           vga_colour;
    logic                 vga_plot;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface
`default_nettype wire

// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : draw_arbiter
// Brief    : Round-robin arbiter sweeping solid rectangles into the VGA port.
// Revision : 1.0
// ============================================================================
module draw_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    draw_arbiter_if.slave     bus
);
    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLOT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_ptr_w-1:0]   ptr_q, ptr_d;
    logic [c_ptr_w-1:0]   gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic [7:0]           x_q, x_d, w_q, w_d, col_q, col_d;
    logic [6:0]           y_q, y_d, h_q, h_d, row_q, row_d;
    logic [2:0]           colour_q, colour_d;
    logic [7:0]           vga_x_q, vga_x_d;
    logic [6:0]           vga_y_q, vga_y_d;
    logic [2:0]           vga_colour_q, vga_colour_d;
    logic                 vga_plot_q, vga_plot_d;

    logic [c_ptr_w:0]     w_search;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_sel_idx;
    logic [7:0]           w_sel_x, w_sel_w;
    logic [6:0]           w_sel_y, w_sel_h;
    logic [2:0]           w_sel_colour;
    logic                 w_pix_en;
    logic [8:0]           w_pix_x;
    logic [7:0]           w_pix_y;
    logic [2:0]           w_pix_colour;

    // Scan downward so the requester closest to the pointer is written last and wins.
    function automatic logic [c_ptr_w:0] find_next(input logic [NUM_REQ-1:0] r,
                                                   input logic [c_ptr_w-1:0] p);
        logic [c_ptr_w:0] res;
        int               k;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(p) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (r[k]) res = {1'b1, c_ptr_w'(k)};
        end
        return res;
    endfunction

    always_comb begin
        w_search     = find_next(bus.req, ptr_q);
        w_found      = w_search[c_ptr_w];
        w_sel_idx    = w_search[c_ptr_w-1:0];
        w_sel_x      = bus.req_x[8*int'(w_sel_idx) +: 8];
        w_sel_y      = bus.req_y[7*int'(w_sel_idx) +: 7];
        w_sel_w      = bus.req_w[8*int'(w_sel_idx) +: 8];
        w_sel_h      = bus.req_h[7*int'(w_sel_idx) +: 7];
        w_sel_colour = bus.req_colour[3*int'(w_sel_idx) +: 3];
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        done_d       = '0;
        busy_d       = busy_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        colour_d     = colour_q;
        col_d        = col_q;
        row_d        = row_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = '0;
        vga_plot_d   = 1'b0;
        w_pix_en     = 1'b0;
        w_pix_x      = '0;
        w_pix_y      = '0;
        w_pix_colour = colour_q;

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    gidx_d   = w_sel_idx;
                    grant_d  = NUM_REQ'(1) << w_sel_idx;
                    busy_d   = 1'b1;
                    x_d      = w_sel_x;
                    y_d      = w_sel_y;
                    w_d      = w_sel_w;
                    h_d      = w_sel_h;
                    colour_d = w_sel_colour;
                    col_d    = '0;
                    row_d    = '0;
                    if (w_sel_w == 8'd0 || w_sel_h == 7'd0) begin
                        state_d = S_DONE;
                        done_d  = NUM_REQ'(1) << w_sel_idx;
                    end else begin
                        state_d      = S_PLOT;
                        w_pix_en     = 1'b1;
                        w_pix_x      = {1'b0, w_sel_x};
                        w_pix_y      = {1'b0, w_sel_y};
                        w_pix_colour = w_sel_colour;
                    end
                end
            end
            // Outputs are registered alongside the state, so this computes the next pixel.
            S_PLOT: begin
                if (col_q == w_q - 8'd1) begin
                    if (row_q == h_q - 7'd1) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                    end else begin
                        col_d    = '0;
                        row_d    = row_q + 7'd1;
                        w_pix_en = 1'b1;
                        w_pix_x  = {1'b0, x_q};
                        w_pix_y  = {1'b0, y_q} + {1'b0, row_q + 7'd1};
                    end
                end else begin
                    col_d    = col_q + 8'd1;
                    w_pix_en = 1'b1;
                    w_pix_x  = {1'b0, x_q} + {1'b0, col_q + 8'd1};
                    w_pix_y  = {1'b0, y_q} + {1'b0, row_q};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = (gidx_q == c_ptr_w'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (w_pix_en) begin
            vga_x_d      = w_pix_x[7:0];
            vga_y_d      = w_pix_y[6:0];
            vga_colour_d = w_pix_colour;
            vga_plot_d   = (w_pix_x < 9'(SCREEN_W)) && (w_pix_y < 8'(SCREEN_H));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gidx_q       <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            colour_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_q          <= w_d;
            h_q          <= h_d;
            colour_q     <= colour_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_arbiter
// Brief    : Directed vector bench for draw_arbiter.
// Revision : 1.0
// ============================================================================
module tb_draw_arbiter;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    draw_arbiter_if #(.NUM_REQ(3)) bus ();

    draw_arbiter #(
        .NUM_REQ (3),
        .SCREEN_W(160),
        .SCREEN_H(120)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] w;
        logic [6:0] h;
        logic [2:0] col;
        int         plots;
        int         cycles;
        int         fx, fy, lx, ly;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_rect(input int idx, input logic [7:0] x, input logic [6:0] y,
                            input logic [7:0] w, input logic [6:0] h, input logic [2:0] c);
        bus.req_x[8*idx +: 8]      = x;
        bus.req_y[7*idx +: 7]      = y;
        bus.req_w[8*idx +: 8]      = w;
        bus.req_h[7*idx +: 7]      = h;
        bus.req_colour[3*idx +: 3] = c;
    endtask

    // Wait for a grant, then for its done pulse; release the request and expect an idle gap.
    task automatic serve(input int idx, input string nm);
        int g;
        g = 0;
        while (bus.grant == 3'b000 && g < 40) begin
            tick();
            g++;
        end
        check({nm, " grant"}, 32'(bus.grant), 32'(1 << idx));
        g = 0;
        while (bus.done == 3'b000 && g < 300) begin
            tick();
            g++;
        end
        check({nm, " done"}, 32'(bus.done), 32'(1 << idx));
        bus.req[idx] = 1'b0;
        tick();
        check({nm, " idle gap"}, 32'({bus.busy, bus.grant}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g, nc, np, fx, fy, lx, ly;
        logic col_ok;

        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{0, 8'd10,  7'd20,  8'd2, 7'd2, 3'd4, 4, 4, 10, 20, 11, 21};
        tbl[1] = '{1, 8'd158, 7'd119, 8'd4, 7'd2, 3'd2, 2, 8, 158, 119, 159, 119};
        tbl[2] = '{2, 8'd0,   7'd0,   8'd3, 7'd1, 3'd7, 3, 3, 0, 0, 2, 0};
        tbl[3] = '{0, 8'd1,   7'd1,   8'd0, 7'd5, 3'd5, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 8'd159, 7'd0,   8'd1, 7'd3, 3'd1, 3, 3, 159, 0, 159, 2};
        tbl[5] = '{2, 8'd200, 7'd10,  8'd2, 7'd2, 3'd3, 0, 4, 0, 0, 0, 0};
        tbl[6] = '{1, 8'd5,   7'd118, 8'd2, 7'd4, 3'd6, 4, 8, 5, 118, 6, 119};
        tbl[7] = '{0, 8'd255, 7'd127, 8'd1, 7'd1, 3'd7, 0, 1, 0, 0, 0, 0};

        bus.req = '0; bus.req_x = '0; bus.req_y = '0;
        bus.req_w = '0; bus.req_h = '0; bus.req_colour = '0;
        reset_n = 1'b0;
        tick();
        tick();
        check("reset grant", 32'(bus.grant), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset pixel", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        reset_n = 1'b1;
        tick();

        // Round robin from pointer 0, then wrap back to 0.
        for (int i = 0; i < 3; i++) set_rect(i, 8'(i), 7'd0, 8'd1, 7'd1, 3'd1);
        bus.req = 3'b111;
        serve(0, "rr0");
        serve(1, "rr1");
        serve(2, "rr2");
        bus.req = 3'b011;
        serve(0, "wrap0");
        serve(1, "wrap1");
        // Pointer at 1: requester 1 wins a tie with requester 0.
        bus.req = 3'b001;
        serve(0, "pre");
        bus.req = 3'b011;
        serve(1, "ptr1 first");
        serve(0, "ptr1 second");

        // Exact per-cycle sweep of a 2x2 fill.
        set_rect(0, 8'd10, 7'd20, 8'd2, 7'd2, 3'b100);
        bus.req = 3'b001;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sweep%0d plot", i), 32'({bus.vga_plot, bus.grant, bus.done}), 32'b1_001_000);
            check($sformatf("sweep%0d x", i), 32'(bus.vga_x), 32'(10 + (i % 2)));
            check($sformatf("sweep%0d y", i), 32'(bus.vga_y), 32'(20 + i / 2));
            check($sformatf("sweep%0d colour", i), 32'(bus.vga_colour), 32'b100);
            if (i == 1) set_rect(0, 8'd90, 7'd90, 8'd9, 7'd9, 3'b011);
            tick();
        end
        check("sweep done", 32'({bus.vga_plot, bus.grant, bus.done, bus.busy}), 32'b0_001_001_1);
        bus.req = 3'b000;
        tick();
        check("sweep idle", 32'({bus.busy, bus.grant, bus.done}), 0);

        for (int t = 0; t < 8; t++) begin
            set_rect(tbl[t].idx, tbl[t].x, tbl[t].y, tbl[t].w, tbl[t].h, tbl[t].col);
            bus.req = 3'(1 << tbl[t].idx);
            g = 0;
            while (bus.grant == 3'b000 && g < 20) begin
                tick();
                g++;
            end
            check($sformatf("tbl%0d grant", t), 32'(bus.grant), 32'(1 << tbl[t].idx));
            nc = 0; np = 0; fx = 0; fy = 0; lx = 0; ly = 0; col_ok = 1'b1;
            while (bus.done == 3'b000 && nc < 300) begin
                if (bus.vga_colour !== tbl[t].col) col_ok = 1'b0;
                if (bus.vga_plot) begin
                    if (np == 0) begin
                        fx = int'(bus.vga_x);
                        fy = int'(bus.vga_y);
                    end
                    lx = int'(bus.vga_x);
                    ly = int'(bus.vga_y);
                    np++;
                end
                nc++;
                tick();
            end
            check($sformatf("tbl%0d cycles", t), 32'(nc), 32'(tbl[t].cycles));
            check($sformatf("tbl%0d plots", t), 32'(np), 32'(tbl[t].plots));
            check($sformatf("tbl%0d colour held", t), 32'(col_ok), 1);
            check($sformatf("tbl%0d done", t), 32'({bus.done, bus.grant, bus.vga_plot}),
                  32'({3'(1 << tbl[t].idx), 3'(1 << tbl[t].idx), 1'b0}));
            if (tbl[t].plots > 0) begin
                check($sformatf("tbl%0d first", t), 32'(fx * 256 + fy), 32'(tbl[t].fx * 256 + tbl[t].fy));
                check($sformatf("tbl%0d last", t), 32'(lx * 256 + ly), 32'(tbl[t].lx * 256 + tbl[t].ly));
            end
            bus.req = 3'b000;
            tick();
            check($sformatf("tbl%0d idle", t), 32'({bus.busy, bus.grant}), 0);
        end

        // Pointer now 1; reset during the third pixel must clear everything including it.
        set_rect(0, 8'd30, 7'd40, 8'd4, 7'd4, 3'd5);
        set_rect(1, 8'd50, 7'd50, 8'd1, 7'd1, 3'd2);
        bus.req = 3'b001;
        tick();
        tick();
        tick();
        check("pre-reset pixel", 32'({bus.vga_plot, bus.vga_x}), 32'({1'b1, 8'd32}));
        reset_n = 1'b0;
        #1;
        check("async reset outputs", 32'({bus.grant, bus.done, bus.busy, bus.vga_plot}), 0);
        check("async reset pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        tick();
        tick();
        check("held reset no done", 32'({bus.done, bus.busy}), 0);
        reset_n = 1'b1;
        bus.req = 3'b011;
        tick();
        check("restart grant", 32'(bus.grant), 32'b001);
        check("restart pixel", 32'({bus.vga_plot, bus.vga_x, bus.vga_y}), 32'({1'b1, 8'd30, 7'd40}));
        serve(0, "restart fill");
        serve(1, "after restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
